tcm_arb_ram: RTL and testbench

Parametrised tightly-coupled memory. NPORTS independent request/grant/rvalid ports share one single-ported byte-enable storage array through a round-robin arbiter. It generalises the fixed CPU/boot/data RAM: port count, width, depth and read latency are configurable. It adds boot-lock mode, out-of-range error reporting and an optional output register. It sits on the core instruction/data fabric of the FPGA system.

---
 rtl/tcm_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/tcm_arb_ram.sv | 154 +++++++++++++++
 tb/tb_tcm_arb_ram.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_pkg.sv
// Shared width helpers and response descriptor for the arbitrated TCM.
package tcm_pkg;

    function automatic int off_w(input int dw);
        return (dw > 8) ? $clog2(dw / 8) : 0;
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic [1:0] port;
        logic       is_read;
        logic       oor;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requestor at or after the
// pointer, then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  elig;
    logic [PW-1:0] ptr_q, ptr_d;

    assign elig = req & mask;

    // Scan offsets from far to near so the nearest eligible index wins last.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            for (int j = 0; j < N; j++) begin
                if (j == (int'(ptr_q) + i) % N && elig[j]) begin
                    gnt    = '0;
                    gnt[j] = 1'b1;
                    ptr_d  = PW'((j + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tcm_arb_ram.sv
// Tightly-coupled memory: NPORTS round-robin requestors share one byte-enable
// storage array, one access per cycle, responses after 1 or 2 cycles.
module tcm_arb_ram
    import tcm_pkg::*;
#(
    parameter int    NPORTS    = 3,
    parameter int    DW        = 32,
    parameter int    DEPTH     = 1024,
    parameter int    AW        = 32,
    parameter int    OUT_REG   = 0,
    parameter int    BOOT_PORT = 0,
    parameter string INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   boot_en,
    input  logic [NPORTS-1:0]      req,
    input  logic [NPORTS-1:0]      we,
    input  logic [NPORTS*AW-1:0]   addr,
    input  logic [NPORTS*DW/8-1:0] be,
    input  logic [NPORTS*DW-1:0]   wdata,
    output logic [NPORTS-1:0]      gnt,
    output logic [NPORTS-1:0]      rvalid,
    output logic [NPORTS*DW-1:0]   rdata,
    output logic [NPORTS-1:0]      err
);
    localparam int BW   = DW / 8;
    localparam int OFFW = off_w(DW);
    localparam int IW   = idx_w(DEPTH);

    logic [DW-1:0]     mem [DEPTH];
    logic [NPORTS-1:0] mask, arb_req;

    logic              any_gnt;
    logic              we_p0;
    logic [AW-1:0]     addr_p0, waddr_p0;
    logic [BW-1:0]     be_p0;
    logic [DW-1:0]     wdata_p0;
    logic [IW-1:0]     widx_p0;
    resp_t             resp_p0;

    logic              vld_p1_q;
    resp_t             resp_p1_q;
    logic [DW-1:0]     data_p1_q;
    logic [NPORTS-1:0] hit_p1;
    logic [DW-1:0]     rd_val_p1;
    logic [DW-1:0]     hold_q [NPORTS];

    always_comb begin
        mask = '1;
        if (boot_en) begin
            mask            = '0;
            mask[BOOT_PORT] = 1'b1;
        end
    end

    // Eligibility is gated by reset so no grant is issued while rst is high.
    assign arb_req = rst ? '0 : req;

    rr_arbiter #(.N(NPORTS)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (arb_req),
        .mask (mask),
        .gnt  (gnt)
    );

    // Stage p0: select the granted port's request and range-check it.
    always_comb begin
        any_gnt  = 1'b0;
        we_p0    = 1'b0;
        addr_p0  = '0;
        be_p0    = '0;
        wdata_p0 = '0;
        resp_p0  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt[i]) begin
                any_gnt      = 1'b1;
                we_p0        = we[i];
                addr_p0      = addr[i*AW +: AW];
                be_p0        = be[i*BW +: BW];
                wdata_p0     = wdata[i*DW +: DW];
                resp_p0.port = 2'(i);
            end
        end
        waddr_p0        = addr_p0 >> OFFW;
        resp_p0.is_read = ~we_p0;
        resp_p0.oor     = (waddr_p0 >= AW'(DEPTH));
        widx_p0         = waddr_p0[IW-1:0];
    end

    always_ff @(posedge clk) begin
        if (any_gnt && we_p0 && !resp_p0.oor) begin
            for (int k = 0; k < BW; k++) begin
                if (be_p0[k]) mem[widx_p0][k*8 +: 8] <= wdata_p0[k*8 +: 8];
            end
        end
        if (any_gnt) begin
            resp_p1_q <= resp_p0;
            data_p1_q <= mem[widx_p0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1_q <= 1'b0;
        else     vld_p1_q <= any_gnt;
    end

    // Stage p1: decode the response to its port; out-of-range reads return 0.
    assign rd_val_p1 = resp_p1_q.oor ? '0 : data_p1_q;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            hit_p1[p] = vld_p1_q && (resp_p1_q.port == 2'(p));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPORTS; p++) hold_q[p] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (hit_p1[p] && resp_p1_q.is_read) hold_q[p] <= rd_val_p1;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [NPORTS-1:0] rvalid_q, err_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rvalid_q <= '0;
                err_q    <= '0;
            end else begin
                rvalid_q <= hit_p1;
                err_q    <= hit_p1 & {NPORTS{resp_p1_q.oor}};
            end
        end

        assign rvalid = rvalid_q;
        assign err    = err_q;
        for (genvar p = 0; p < NPORTS; p++) begin : g_rd
            assign rdata[p*DW +: DW] = hold_q[p];
        end
    end else begin : g_comb
        assign rvalid = hit_p1;
        assign err    = hit_p1 & {NPORTS{resp_p1_q.oor}};
        for (genvar p = 0; p < NPORTS; p++) begin : g_rd
            assign rdata[p*DW +: DW] = (hit_p1[p] && resp_p1_q.is_read) ? rd_val_p1 : hold_q[p];
        end
    end

endmodule

// File: tb/tb_tcm_arb_ram.sv
// Bench for tcm_arb_ram: two instances (OUT_REG=0 and 1) share stimulus; a
// scoreboard of expected responses is drained by a negedge monitor.
module tb_tcm_arb_ram;
    localparam int NP = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             boot_en = 1'b0;
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*BW-1:0] be = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP-1:0]    gnt0, gnt1, rv0, rv1, err0, err1;
    logic [NP*DW-1:0] rd0, rd1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        logic        rd;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl [int];
    exp_t        m0, m1;
    logic [NP-1:0] ev0, ev1;

    tcm_arb_ram #(.NPORTS(NP), .DW(DW), .DEPTH(1024), .AW(AW), .OUT_REG(0),
                  .BOOT_PORT(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst), .boot_en(boot_en), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .gnt(gnt0), .rvalid(rv0), .rdata(rd0), .err(err0));

    tcm_arb_ram #(.NPORTS(NP), .DW(DW), .DEPTH(1024), .AW(AW), .OUT_REG(1),
                  .BOOT_PORT(0), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .boot_en(boot_en), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .err(err1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: a response is due exactly on its recorded cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (q0.size() > 0 && q0[0].due == cyc) begin
                m0 = q0.pop_front();
                ev0 = '0; ev0[m0.port] = 1'b1;
                if (rv0 !== ev0 || err0[m0.port] !== m0.err ||
                    (m0.rd && rd0[m0.port*DW +: DW] !== m0.data)) begin
                    errors++;
                    $display("FAIL resp0 cyc=%0d rvalid=%b err=%b rdata=%h, want rvalid=%b err=%b rdata=%h",
                             cyc, rv0, err0, rd0[m0.port*DW +: DW], ev0, m0.err, m0.data);
                end
            end else if (rv0 !== '0) begin
                errors++;
                $display("FAIL idle0 cyc=%0d rvalid=%b want 000", cyc, rv0);
            end
            checks++;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                m1 = q1.pop_front();
                ev1 = '0; ev1[m1.port] = 1'b1;
                if (rv1 !== ev1 || err1[m1.port] !== m1.err ||
                    (m1.rd && rd1[m1.port*DW +: DW] !== m1.data)) begin
                    errors++;
                    $display("FAIL resp1 cyc=%0d rvalid=%b err=%b rdata=%h, want rvalid=%b err=%b rdata=%h",
                             cyc, rv1, err1, rd1[m1.port*DW +: DW], ev1, m1.err, m1.data);
                end
            end else if (rv1 !== '0) begin
                errors++;
                $display("FAIL idle1 cyc=%0d rvalid=%b want 000", cyc, rv1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[p]              = r;
        we[p]               = w;
        addr[p*AW +: AW]    = a;
        be[p*BW +: BW]      = b;
        wdata[p*DW +: DW]   = d;
    endtask

    // Record a granted access in the reference memory and queue its response.
    task automatic expect_access(input int p, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d);
        exp_t        e;
        int          wi;
        logic [31:0] old;
        wi     = int'(a >> 2);
        e.port = p;
        e.rd   = !w;
        e.err  = (wi >= 1024);
        e.data = 32'h0;
        e.due  = cyc + 1;
        if (!e.err) begin
            old = mdl.exists(wi) ? mdl[wi] : 32'h0;
            if (w) begin
                for (int k = 0; k < 4; k++) if (b[k]) old[k*8 +: 8] = d[k*8 +: 8];
                mdl[wi] = old;
            end else begin
                e.data = old;
            end
        end
        q0.push_back(e);
        e.due = cyc + 2;
        q1.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        boot_en = 1'b0;
        repeat (2) tick();
        q0.delete();
        q1.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        repeat (2) tick();
        checks++; if (gnt0 !== 3'b000) begin errors++; $display("FAIL rst_gnt0 got=%b want=000", gnt0); end
        checks++; if (gnt1 !== 3'b000) begin errors++; $display("FAIL rst_gnt1 got=%b want=000", gnt1); end
        checks++; if (rv0 !== 3'b000 || rv1 !== 3'b000) begin errors++; $display("FAIL rst_rvalid got=%b/%b want=000", rv0, rv1); end
        checks++; if (err0 !== 3'b000 || err1 !== 3'b000) begin errors++; $display("FAIL rst_err got=%b/%b want=000", err0, err1); end
        checks++; if (rd0 !== '0) begin errors++; $display("FAIL rst_rdata0 got=%h want=0", rd0); end
        checks++; if (rd1 !== '0) begin errors++; $display("FAIL rst_rdata1 got=%h want=0", rd1); end
        req = '0;
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_single_read();
        tick();
        drive(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        #1;
        checks++; if (gnt0 !== 3'b010 || gnt1 !== 3'b010) begin errors++; $display("FAIL sr_wr_gnt got=%b/%b want=010", gnt0, gnt1); end
        expect_access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        tick();
        drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        checks++; if (gnt0 !== 3'b010 || gnt1 !== 3'b010) begin errors++; $display("FAIL sr_rd_gnt got=%b/%b want=010", gnt0, gnt1); end
        expect_access(1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        req = '0;
        repeat (3) tick();
        checks++;
        if (rd0[DW +: DW] !== 32'hDEADBEEF || rd1[DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sr_hold got=%h/%h want=deadbeef", rd0[DW +: DW], rd1[DW +: DW]);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] dat [4] = '{32'hAAAAAAAA, 32'h11223344, 32'hFFFFFFFF, 32'h0};
        logic [3:0]  bes [4] = '{4'hF, 4'b0101, 4'b0000, 4'h0};
        logic        wes [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(0, 1'b1, wes[i], 32'h20, bes[i], dat[i]);
            #1;
            checks++; if (gnt0 !== 3'b001 || gnt1 !== 3'b001) begin errors++; $display("FAIL be_gnt step=%0d got=%b/%b want=001", i, gnt0, gnt1); end
            expect_access(0, wes[i], 32'h20, bes[i], dat[i]);
        end
        tick();
        req = '0;
        repeat (3) tick();
        checks++;
        if (rd0[31:0] !== 32'hAA22AA44 || rd1[31:0] !== 32'hAA22AA44) begin
            errors++;
            $display("FAIL be_data got=%h/%h want=aa22aa44", rd0[31:0], rd1[31:0]);
        end
    endtask

    task automatic test_fairness();
        logic [31:0] pa [3] = '{32'h10, 32'h20, 32'h10};
        logic [2:0]  eg;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, pa[p], 4'h0, 32'h0);
            #1;
            eg = '0; eg[i % 3] = 1'b1;
            checks++; if (gnt0 !== eg || gnt1 !== eg) begin errors++; $display("FAIL rr_gnt step=%0d got=%b/%b want=%b", i, gnt0, gnt1, eg); end
            expect_access(i % 3, 1'b0, pa[i % 3], 4'h0, 32'h0);
        end
        tick();
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_boot_lock();
        do_reset();
        tick();
        boot_en = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        checks++; if (gnt0 !== 3'b000 || gnt1 !== 3'b000) begin errors++; $display("FAIL boot_block got=%b/%b want=000", gnt0, gnt1); end
        tick();
        req[1] = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            checks++; if (gnt0 !== 3'b001 || gnt1 !== 3'b001) begin errors++; $display("FAIL boot_gnt step=%0d got=%b/%b want=001", i, gnt0, gnt1); end
            expect_access(0, 1'b0, 32'h10, 4'h0, 32'h0);
        end
        tick();
        boot_en = 1'b0;
        #1;
        checks++; if (gnt0 !== 3'b100 || gnt1 !== 3'b100) begin errors++; $display("FAIL boot_release got=%b/%b want=100", gnt0, gnt1); end
        expect_access(2, 1'b0, 32'h20, 4'h0, 32'h0);
        tick();
        req[2] = 1'b0;
        #1;
        checks++; if (gnt0 !== 3'b001 || gnt1 !== 3'b001) begin errors++; $display("FAIL boot_after got=%b/%b want=001", gnt0, gnt1); end
        expect_access(0, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_oor();
        int          tp [6] = '{0, 2, 0, 0, 1, 1};
        logic        tw [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ta [6] = '{32'h0, 32'h1000, 32'h0, 32'h1003, 32'hFFC, 32'hFFF};
        logic [31:0] td [6] = '{32'h0BADF00D, 32'h0, 32'h0, 32'h0, 32'hC0FFEE00, 32'h0};
        logic [2:0]  eg;
        tick();
        drive(2, 1'b1, 1'b1, 32'h1000, 4'hF, 32'h55555555);
        #1;
        checks++; if (gnt0 !== 3'b100 || gnt1 !== 3'b100) begin errors++; $display("FAIL oor_wr_gnt got=%b/%b want=100", gnt0, gnt1); end
        expect_access(2, 1'b1, 32'h1000, 4'hF, 32'h55555555);
        tick();
        req = '0;
        repeat (3) tick();
        checks++;
        if (rd0[2*DW +: DW] !== 32'hAA22AA44 || rd1[2*DW +: DW] !== 32'hAA22AA44) begin
            errors++;
            $display("FAIL oor_wr_hold got=%h/%h want=aa22aa44", rd0[2*DW +: DW], rd1[2*DW +: DW]);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            req = '0;
            drive(tp[i], 1'b1, tw[i], ta[i], 4'hF, td[i]);
            #1;
            eg = '0; eg[tp[i]] = 1'b1;
            checks++; if (gnt0 !== eg || gnt1 !== eg) begin errors++; $display("FAIL oor_gnt step=%0d got=%b/%b want=%b", i, gnt0, gnt1, eg); end
            expect_access(tp[i], tw[i], ta[i], 4'hF, td[i]);
        end
        tick();
        req = '0;
        repeat (3) tick();
        checks++;
        if (rd0[2*DW +: DW] !== 32'h0 || rd1[2*DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL oor_rd_zero got=%h/%h want=0", rd0[2*DW +: DW], rd1[2*DW +: DW]);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        checks++; if (gnt0 !== 3'b010 || gnt1 !== 3'b010) begin errors++; $display("FAIL rm_gnt got=%b/%b want=010", gnt0, gnt1); end
        tick();
        rst = 1'b1;
        req = '0;
        #1;
        checks++; if (rv0 !== 3'b000 || rv1 !== 3'b000) begin errors++; $display("FAIL rm_flush got=%b/%b want=000", rv0, rv1); end
        repeat (2) tick();
        rst = 1'b0;
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        checks++; if (gnt0 !== 3'b001 || gnt1 !== 3'b001) begin errors++; $display("FAIL rm_ptr got=%b/%b want=001", gnt0, gnt1); end
        expect_access(0, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        req = '0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_enable();
        test_fairness();
        test_boot_lock();
        test_oor();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d/%0d want=0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
